// File: rtl/bus_read_master_pkg.sv
// Shared bus definitions for the read master: state encoding, default widths,
// responder address and the timeout-limit helper.
`default_nettype none

package bus_read_master_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 16;
  localparam int TIMER_W     = 8;

  localparam logic [DEF_ADDR_W-1:0] RESP_ADDR = 8'h3C;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_REL  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // Terminal timer value: the wait expires once the count has reached it.
  function automatic logic [TIMER_W-1:0] timer_limit(input int timeout);
    return TIMER_W'(timeout - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bus_timeout_ctr.sv
// Wait timer for the read master: counts cycles while enabled and flags
// expiry when the count reaches TIMEOUT-1.
`default_nettype none

module bus_timeout_ctr
  import bus_read_master_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT = timer_limit(TIMEOUT);

  logic [TIMER_W-1:0] count;

  // Saturates at LIMIT so a held enable never wraps back to a short wait.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);

endmodule

`default_nettype wire

// File: rtl/bus_read_master.sv
// Handshaked bus read master: issues rd to one address for len+1 words,
// captures D on each Den, and aborts with timeout_err if Den stalls.
`default_nettype none

module bus_read_master
  import bus_read_master_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [3:0]        len,
  output logic [ADDR_W-1:0] A,
  output logic              rd,
  input  logic              Den,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              timeout_err
);

  state_t     state;
  logic [3:0] cnt;
  logic       wait_en;
  logic       timer_clr;
  logic       timer_expired;

  // The timer runs only while the level the current state waits for is absent;
  // any other cycle (including every state transition) restarts it from zero.
  always_comb begin
    wait_en = 1'b0;
    case (state)
      ST_REQ:  wait_en = !Den;
      ST_REL:  wait_en = Den;
      default: wait_en = 1'b0;
    endcase
  end

  assign timer_clr = !wait_en;

  bus_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (wait_en),
    .expired(timer_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      A           <= '0;
      rd          <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= 4'd0;
    end else begin
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_REQ;
            A     <= addr_in;
            cnt   <= len;
            rd    <= 1'b1;
            busy  <= 1'b1;
          end
        end

        // Den is checked before expiry so a response on the final cycle wins.
        ST_REQ: begin
          if (Den) begin
            rdata       <= D;
            rdata_valid <= 1'b1;
            rd          <= 1'b0;
            state       <= ST_REL;
          end else if (timer_expired) begin
            rd          <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_ERR;
          end
        end

        ST_REL: begin
          if (!Den) begin
            if (cnt == 4'd0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              cnt   <= cnt - 4'd1;
              rd    <= 1'b1;
              state <= ST_REQ;
            end
          end else if (timer_expired) begin
            timeout_err <= 1'b1;
            state       <= ST_ERR;
          end
        end

        ST_DONE, ST_ERR: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          rd    <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bus_read_master.sv
// Directed bench for bus_read_master: table of bursts against a simple
// responder, plus reset, idle-Den and mid-burst reset sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_bus_read_master;
  import bus_read_master_pkg::*;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] addr_in;
  logic [3:0] len;
  logic [7:0] A;
  logic       rd;
  logic       Den;
  logic [7:0] D;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       busy;
  logic       done;
  logic       timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bus_read_master #(
    .ADDR_W (8),
    .DATA_W (8),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .addr_in    (addr_in),
    .len        (len),
    .A          (A),
    .rd         (rd),
    .Den        (Den),
    .D          (D),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err)
  );

  // d: rd-high cycles before Den rises; h: extra cycles Den stays high after capture.
  // Sample indices count cycles after the start edge; -1 means the event must not occur.
  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  len;
    int          d;
    int          h;
    logic [31:0] data;
    int          poke;
    int          exp_valids;
    int          exp_done;
    int          exp_err;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t tv[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int hi, lo, nval, done_idx, err_idx, end_idx, viol, exp_end;
    logic prev_rd;
    hi = 0; lo = 0; nval = 0; done_idx = -1; err_idx = -1; end_idx = -1; viol = 0;
    prev_rd = 1'b0;
    exp_end = (v.exp_done >= 0) ? v.exp_done + 1 : v.exp_err + 1;
    addr_in = v.addr; len = v.len; start = 1'b1; Den = 1'b0; D = 8'hEE;
    tick();
    for (int idx = 0; idx < 300; idx++) begin
      start   = (idx == v.poke);
      addr_in = 8'h77;
      if (rdata_valid) begin
        check($sformatf("v%0d word%0d", n, nval), rdata, v.data[8*(nval%4) +: 8]);
        nval++;
      end
      if (done) begin
        if (done_idx < 0) done_idx = idx; else viol++;
      end
      if (timeout_err) begin
        if (err_idx < 0) err_idx = idx; else viol++;
      end
      if (busy && A !== v.addr) viol++;
      if (rd && (rdata_valid || done || timeout_err)) viol++;
      if (rd && !prev_rd && Den) viol++;
      if (!busy) begin
        end_idx = idx;
        break;
      end
      prev_rd = rd;
      if (rd) begin
        hi++;
        lo  = 0;
        Den = (hi > v.d);
      end else begin
        hi = 0;
        if (Den && lo < v.h) lo++;
        else Den = 1'b0;
      end
      D = Den ? v.data[8*(nval%4) +: 8] : 8'hEE;
      tick();
    end
    start = 1'b0; Den = 1'b0; D = 8'h00;
    if (end_idx < 0) begin
      total++;
      bad++;
      $display("FAIL v%0d bound: busy still high after 300 cycles", n);
    end
    check($sformatf("v%0d valids", n), nval, v.exp_valids);
    check($sformatf("v%0d done_idx", n), done_idx, v.exp_done);
    check($sformatf("v%0d err_idx", n), err_idx, v.exp_err);
    check($sformatf("v%0d end_idx", n), end_idx, exp_end);
    check($sformatf("v%0d last_rdata", n), rdata, v.exp_last);
    check($sformatf("v%0d protocol_viol", n), viol, 0);
    tick();
    check($sformatf("v%0d idle_after", n), {busy, rd, rdata_valid}, 3'b000);
  endtask

  initial begin
    //           addr       len  d   h    data          poke val done err last
    tv[0] = '{8'h3C,     4'd0,  3,  0, 32'h000000A5, -1,  1,  5, -1, 8'hA5};
    tv[1] = '{8'h3C,     4'd3,  1,  1, 32'h08040201, -1,  4, 16, -1, 8'h08};
    tv[2] = '{8'h10,     4'd0,  0,  0, 32'h0000005B,  2,  1,  2, -1, 8'h5B};
    tv[3] = '{8'h20,     4'd0, 15,  0, 32'h000000C3, -1,  1, 17, -1, 8'hC3};
    tv[4] = '{8'h30,     4'd0, 16,  0, 32'h000000FF, 16,  0, -1, 16, 8'hC3};
    tv[5] = '{8'h40,     4'd1,  0, 255, 32'h00003311, -1, 1, -1, 17, 8'h11};
    tv[6] = '{8'h50,     4'd0,  0, 15, 32'h00000024, -1,  1, 17, -1, 8'h24};
    tv[7] = '{8'h60,     4'd0,  0, 16, 32'h00000042, -1,  1, -1, 17, 8'h42};
    tv[8] = '{8'h55,     4'd2,  2,  1, 32'h00CCBBAA,  3,  3, 15, -1, 8'hCC};
    tv[9] = '{RESP_ADDR, 4'd15, 0,  0, 32'h44332211, -1, 16, 32, -1, 8'h44};

    // Reset held with start and Den asserted: reset must dominate.
    rst = 1'b1; start = 1'b1; Den = 1'b1; D = 8'h99; addr_in = 8'h5A; len = 4'hF;
    tick();
    tick();
    check("reset A", A, 8'h00);
    check("reset rd", rd, 1'b0);
    check("reset rdata", rdata, 8'h00);
    check("reset rdata_valid", rdata_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset timeout_err", timeout_err, 1'b0);

    // Den high while idle must be ignored.
    rst = 1'b0; start = 1'b0; Den = 1'b1; D = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_den cyc%0d", i), {rdata_valid, timeout_err, busy, rd}, 4'b0000);
    end
    check("idle_den rdata", rdata, 8'h00);
    Den = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_vec(tv[i], i);
    end

    // Reset during the second read of a len=5 burst.
    addr_in = 8'h21; len = 4'd5; start = 1'b1; Den = 1'b0; D = 8'hEE;
    tick();
    start = 1'b0; addr_in = 8'h77;
    check("rst_seq first rd", rd, 1'b1);
    Den = 1'b1; D = 8'h5A;
    tick();
    check("rst_seq capture", {rdata_valid, rdata}, {1'b1, 8'h5A});
    Den = 1'b0; D = 8'hEE;
    tick();
    check("rst_seq second rd", {rd, busy}, 2'b11);
    rst = 1'b1; start = 1'b1; Den = 1'b1; D = 8'h66;
    tick();
    check("rst_seq outputs", {A, rd, rdata, rdata_valid, busy, done, timeout_err}, 21'd0);
    rst = 1'b0; start = 1'b0; Den = 1'b0;
    tick();
    check("rst_seq stays idle", {busy, rd}, 2'b00);
    run_vec(tv[1], 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_read_master.md
BUS_READ_MASTER -- requirements
Module: bus_read_master

Interface
REQ-001 Parameter: ADDR_W, 8, width of bus address A.
REQ-002 Parameter: DATA_W, 8, width of bus data D and of rdata.
REQ-003 Parameter: TIMEOUT, 16, maximum cycles to wait for the expected Den level; legal range 2..255.
REQ-004 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-005 Port: rst  in  1  synchronous, active-high reset.
REQ-006 Port: start  in  1  user request; sampled only in IDLE.
REQ-007 Port: addr_in  in  ADDR_W  target responder address; latched on accepted start.
REQ-008 Port: len  in  4  burst length minus one (0 -> 1 read, 15 -> 16 reads); latched on accepted start.
REQ-009 Port: A  out  ADDR_W  bus address; registered.
REQ-010 Port: rd  out  1  bus read strobe; registered.
REQ-011 Port: Den  in  1  responder data-enable; D valid while high.
REQ-012 Port: D  in  DATA_W  responder read data.
REQ-013 Port: rdata  out  DATA_W  captured read word.
REQ-014 Port: rdata_valid  out  1  one-cycle pulse per captured word.
REQ-015 Port: busy  out  1  high in every state except IDLE.
REQ-016 Port: done  out  1  one-cycle pulse after the last word of a burst.
REQ-017 Port: timeout_err  out  1  one-cycle pulse on bus timeout.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, REL, DONE and ERR.
- IDLE: start=1 -> REQ; latch addr_in into A; latch len into remaining-count cnt; clear timer.
- REQ: rd=1. At the edge where Den=1: rdata<=D, rdata_valid=1 in the next cycle, go to REL.
- REL: rd=0. At the edge where Den=0: if cnt=0 go to DONE, else cnt<=cnt-1 and go to REQ.
- DONE: done=1 for one cycle, then IDLE.
- ERR: timeout_err=1 for one cycle, then IDLE.
REQ-019 Latency SHALL be 1 cycle from start sampled to rd=1, and 1 cycle from Den=1 sampled to rdata_valid=1 (rd=0 in the same cycle).
REQ-020 rd SHALL stay low for at least one cycle between consecutive reads, and SHALL NOT re-assert until Den has been sampled low.
REQ-021 A SHALL stay constant from the accepted start until IDLE is re-entered; every read of a burst uses the same address.
REQ-022 The timer SHALL clear on every entry to REQ or REL and increment each cycle the expected Den level is absent.
REQ-023 Timeout: the timer reaching TIMEOUT-1 without the expected Den level SHALL cause ERR next, with rd=0. Any burst remainder SHALL be abandoned, and done SHALL NOT pulse.
REQ-024 start while busy=1 SHALL be ignored with no queuing; start in the DONE/ERR cycle SHALL be ignored.
REQ-025 Den=1 in IDLE, DONE or ERR SHALL be ignored; no capture and no error.
REQ-026 Den already 1 on REQ entry SHALL be captured at the first REQ edge (minimum read = 1 cycle of rd).
REQ-027 Expected Den arriving on the same edge the timer hits TIMEOUT-1: Den SHALL win (capture/advance, no error).
REQ-028 rdata SHALL hold its last captured value until the next capture.

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE from any state, including mid-burst. It SHALL set A=0, rd=0, rdata=0, rdata_valid=0, busy=0, done=0, timeout_err=0, cnt=0 and timer=0.
REQ-030 rst SHALL take priority over start and Den in the same cycle; no pulse output is emitted on the reset edge.

Structure
REQ-031 A shared bus package SHALL hold the FSM state encoding constants, the default ADDR_W/DATA_W, and the responder address constant used by the system.
REQ-032 The timeout timer SHALL be a sub-module named bus_timeout_ctr (inputs clr and en; output expired), instantiated once.

Verification
REQ-033 Single read: addr_in=8'h3C, len=0, responder raises Den 3 cycles after rd with D=8'hA5 -> rdata=8'hA5, one rdata_valid, done 2 cycles later, A=8'h3C throughout.
REQ-034 Burst: len=3, D sequence 8'h01,8'h02,8'h04,8'h08 -> exactly 4 rdata_valid pulses in order, 4 rd pulses separated by at least 1 low cycle, one done.
REQ-035 Timeout: Den held 0, TIMEOUT=16 -> timeout_err pulses, rd falls, no rdata_valid, no done, busy=0 afterwards.
REQ-036 Stuck Den: Den stays 1 after the first capture of a len=1 burst -> timeout in REL, timeout_err pulses, only 1 rdata_valid.
REQ-037 Reset mid-burst: assert rst during the 2nd read of a len=5 burst -> next cycle all outputs 0 and IDLE; a new start then runs a clean burst.
REQ-038 Ignored start: pulse start with addr_in=8'h77 while busy -> A unchanged and burst count unchanged.
